jk_reg_bank: RTL

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank.sv | 76 +++++++
 1 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH independent JK flip-flops with parallel load, change flag and saturating toggle counter.
// Define JK_REG_BANK_SYNC_CLR_EN to add the synchronous clr input.
module jk_reg_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef JK_REG_BANK_SYNC_CLR_EN
    input  logic             clr,
`endif
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             changed,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clr_i;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic             changed_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next;
    logic             tog_evt;

`ifdef JK_REG_BANK_SYNC_CLR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    always_comb begin
        q_next   = q_r;
        cnt_next = cnt_r;
        tog_evt  = 1'b0;
        if (clr_i) begin
            q_next   = RESET_VAL;
            cnt_next = '0;
        end else if (load) begin
            q_next = d;
        end else if (en) begin
            // Per-bit JK: hold / clear / set / invert in one expression
            q_next  = (q_r & ~k) | (~q_r & j);
            tog_evt = |(j & k);
        end
        if (tog_evt && (cnt_r != CNT_MAX)) begin
            cnt_next = cnt_r + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r       <= RESET_VAL;
            changed_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            q_r       <= q_next;
            changed_r <= (q_next != q_r);
            cnt_r     <= cnt_next;
        end
    end

    assign q          = q_r;
    assign qn         = ~q_r;
    assign changed    = changed_r;
    assign toggle_cnt = cnt_r;

endmodule
